// File: rtl/wallace_acc_seq.sv
// wallace: carry-save compressor. Reduces D_N unsigned operands to a redundant
// (sum, carry) pair whose modulo-2^DO_W total equals the operand total.
//   i_data  : D_N operands, operand k at [k*DI_W +: DI_W], zero-extended to DO_W
//   o_sum   : partial sum vector
//   o_carry : carry vector, already shifted to its arithmetic weight
module wallace #(
    parameter int unsigned D_N  = 6,
    parameter int unsigned DI_W = 24,
    parameter int unsigned DO_W = 24
) (
    input  logic [D_N*DI_W-1:0] i_data,
    output logic [DO_W-1:0]     o_sum,
    output logic [DO_W-1:0]     o_carry
);

    logic [DO_W-1:0] s, c, x, maj;

    // Chain of 3:2 counters: each operand beyond the first two is folded into
    // the running (s, c) pair without any carry propagation.
    always_comb begin
        x   = '0;
        maj = '0;
        s   = DO_W'(i_data[0 +: DI_W]);
        c   = DO_W'(i_data[DI_W +: DI_W]);
        for (int i = 2; i < D_N; i++) begin
            x   = DO_W'(i_data[i*DI_W +: DI_W]);
            maj = (s & c) | (s & x) | (c & x);
            s   = s ^ c ^ x;
            c   = maj << 1;
        end
    end

    assign o_sum   = s;
    assign o_carry = c;

endmodule

// wallace_acc_seq: multi-beat accumulation sequencer. Accumulates up to LANES
// operands per accepted beat into a redundant (sum, carry) accumulator, then
// resolves it with a single carry-propagate add at end of list.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_vld/o_rdy         : input beat handshake
//   i_data, i_lane_en   : operands and per-lane enable (disabled lane adds 0)
//   i_last              : last beat of the list
//   i_abort             : synchronous abort, drops list and any pending result
//   o_vld/i_rdy         : result handshake
//   o_sum, o_cnt        : result (mod 2^DO_W) and saturating beat count
module wallace_acc_seq #(
    parameter int unsigned DI_W  = 16,
    parameter int unsigned DO_W  = 24,
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_vld,
    output logic                  o_rdy,
    input  logic [LANES*DI_W-1:0] i_data,
    input  logic [LANES-1:0]      i_lane_en,
    input  logic                  i_last,
    input  logic                  i_abort,
    output logic                  o_vld,
    input  logic                  i_rdy,
    output logic [DO_W-1:0]       o_sum,
    output logic [CNT_W-1:0]      o_cnt
);

    typedef enum logic [1:0] {StAcc, StFinal, StOut} state_e;

    state_e state_q, state_d;

    logic [DO_W-1:0]  acc_s_q, acc_s_d;
    logic [DO_W-1:0]  acc_c_q, acc_c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DO_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             vld_q, vld_d;

    logic                        accept;
    logic [(LANES+2)*DO_W-1:0]   csa_in;
    logic [DO_W-1:0]             csa_s, csa_c;

    assign accept = i_vld && o_rdy;

    // Masked lanes first, then the two accumulator halves.
    always_comb begin
        csa_in = '0;
        for (int k = 0; k < LANES; k++) begin
            csa_in[k*DO_W +: DO_W] = i_lane_en[k] ? DO_W'(i_data[k*DI_W +: DI_W]) : '0;
        end
        csa_in[LANES*DO_W +: DO_W]     = acc_s_q;
        csa_in[(LANES+1)*DO_W +: DO_W] = acc_c_q;
    end

    wallace #(
        .D_N  (LANES + 2),
        .DI_W (DO_W),
        .DO_W (DO_W)
    ) u_wallace (
        .i_data  (csa_in),
        .o_sum   (csa_s),
        .o_carry (csa_c)
    );

    // State register and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StAcc;
            acc_s_q <= '0;
            acc_c_q <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            ocnt_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_s_q <= acc_s_d;
            acc_c_q <= acc_c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ocnt_q  <= ocnt_d;
            vld_q   <= vld_d;
        end
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = StAcc;
        end else begin
            unique case (state_q)
                StAcc:   if (accept && i_last) state_d = StFinal;
                StFinal: state_d = StOut;
                StOut:   if (i_rdy) state_d = StAcc;
                default: state_d = StAcc;
            endcase
        end
    end

    // Datapath next values.
    always_comb begin
        acc_s_d = acc_s_q;
        acc_c_d = acc_c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        ocnt_d  = ocnt_q;
        if (i_abort) begin
            acc_s_d = '0;
            acc_c_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StAcc: begin
                    if (accept) begin
                        acc_s_d = csa_s;
                        acc_c_d = csa_c;
                        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    end
                end
                StFinal: begin
                    sum_d   = acc_s_q + acc_c_q;
                    ocnt_d  = cnt_q;
                    acc_s_d = '0;
                    acc_c_d = '0;
                    cnt_d   = '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs: valid tracks the registered OUT state; ready decodes state only.
    always_comb begin
        vld_d = (state_d == StOut);
        o_rdy = (state_q == StAcc);
        o_vld = vld_q;
        o_sum = sum_q;
        o_cnt = ocnt_q;
    end

endmodule

// File: tb/tb_wallace_acc_seq.sv
module tb_wallace_acc_seq;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_vld;
    logic        o_rdy;
    logic [63:0] i_data;
    logic [3:0]  i_lane_en;
    logic        i_last;
    logic        i_abort;
    logic        o_vld;
    logic        i_rdy;
    logic [23:0] o_sum;
    logic [7:0]  o_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] ALL_F = {4{16'hFFFF}};
    localparam logic [63:0] D1234 = {16'd4, 16'd3, 16'd2, 16'd1};

    always #5 i_clk = ~i_clk;

    wallace_acc_seq #(
        .DI_W  (16),
        .DO_W  (24),
        .LANES (4),
        .CNT_W (8)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_vld     (i_vld),
        .o_rdy     (o_rdy),
        .i_data    (i_data),
        .i_lane_en (i_lane_en),
        .i_last    (i_last),
        .i_abort   (i_abort),
        .o_vld     (o_vld),
        .i_rdy     (i_rdy),
        .o_sum     (o_sum),
        .o_cnt     (o_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic [3:0] en, input logic last);
        i_vld     = 1'b1;
        i_data    = d;
        i_lane_en = en;
        i_last    = last;
        step();
        i_vld  = 1'b0;
        i_last = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [23:0] es, input logic [7:0] ec);
        for (int k = 0; k < 8 && o_vld !== 1'b1; k++) step();
        check({tag, "_vld"}, {31'd0, o_vld}, 32'd1);
        check({tag, "_sum"}, {8'd0, o_sum}, {8'd0, es});
        check({tag, "_cnt"}, {24'd0, o_cnt}, {24'd0, ec});
        i_rdy = 1'b1;
        step();
        i_rdy = 1'b0;
        check({tag, "_vld_drop"}, {31'd0, o_vld}, 32'd0);
        check({tag, "_rdy_back"}, {31'd0, o_rdy}, 32'd1);
    endtask

    initial begin
        i_rst = 1'b1; i_vld = 1'b0; i_data = '0; i_lane_en = '0;
        i_last = 1'b0; i_abort = 1'b0; i_rdy = 1'b0;
        step();
        step();
        check("rst_vld", {31'd0, o_vld}, 32'd0);
        check("rst_sum", {8'd0, o_sum}, 32'd0);
        check("rst_cnt", {24'd0, o_cnt}, 32'd0);
        i_rst = 1'b0;
        step();
        check("rst_rdy", {31'd0, o_rdy}, 32'd1);

        // Single beat: exact latency check.
        beat(D1234, 4'b1111, 1'b1);
        check("t1_final_rdy", {31'd0, o_rdy}, 32'd0);
        check("t1_final_vld", {31'd0, o_vld}, 32'd0);
        step();
        check("t1_out_vld", {31'd0, o_vld}, 32'd1);
        check("t1_out_rdy", {31'd0, o_rdy}, 32'd0);
        collect("t1", 24'd10, 8'd1);
        check("t1_sum_held", {8'd0, o_sum}, 32'd10);

        // Three full beats with gaps, then backpressure on the result.
        beat(ALL_F, 4'b1111, 1'b0);
        step(); step();
        beat(ALL_F, 4'b1111, 1'b0);
        step();
        beat(ALL_F, 4'b1111, 1'b1);
        step();
        check("t2_vld", {31'd0, o_vld}, 32'd1);
        i_vld = 1'b1; i_data = {48'd0, 16'd5}; i_lane_en = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_vld", {31'd0, o_vld}, 32'd1);
            check("bp_sum", {8'd0, o_sum}, 32'h0BFFF4);
            check("bp_cnt", {24'd0, o_cnt}, 32'd3);
            check("bp_rdy", {31'd0, o_rdy}, 32'd0);
        end
        i_vld = 1'b0;
        collect("t2", 24'h0BFFF4, 8'd3);
        beat({48'd0, 16'd5}, 4'b1111, 1'b1);
        collect("bp_next", 24'd5, 8'd1);

        // 257 beats: wrapped sum and saturated count.
        for (int i = 0; i < 257; i++) beat(ALL_F, 4'b1111, i == 256);
        collect("t3", 24'h03FBFC, 8'd255);

        // Lane masking and an all-disabled last beat.
        beat(D1234, 4'b0101, 1'b0);
        beat(D1234, 4'b0000, 1'b1);
        collect("t4", 24'd4, 8'd2);

        // Abort in the same cycle as a valid beat, mid-list.
        beat(D1234, 4'b1111, 1'b0);
        i_abort = 1'b1;
        beat(D1234, 4'b1111, 1'b1);
        i_abort = 1'b0;
        check("ab1_rdy", {31'd0, o_rdy}, 32'd1);
        check("ab1_vld", {31'd0, o_vld}, 32'd0);
        step();
        check("ab1_no_result", {31'd0, o_vld}, 32'd0);
        beat({48'd0, 16'd7}, 4'b1111, 1'b1);
        collect("ab1", 24'd7, 8'd1);

        // Abort while the result is pending.
        beat({48'd0, 16'd9}, 4'b1111, 1'b1);
        step();
        check("ab2_vld_pre", {31'd0, o_vld}, 32'd1);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check("ab2_vld_drop", {31'd0, o_vld}, 32'd0);
        check("ab2_rdy", {31'd0, o_rdy}, 32'd1);
        beat({48'd0, 16'd7}, 4'b1111, 1'b1);
        collect("ab2", 24'd7, 8'd1);

        // Asynchronous reset mid-list.
        beat(D1234, 4'b1111, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        check("rst2_sum", {8'd0, o_sum}, 32'd0);
        check("rst2_cnt", {24'd0, o_cnt}, 32'd0);
        check("rst2_vld", {31'd0, o_vld}, 32'd0);
        i_rst = 1'b0;
        step();
        check("rst2_rdy", {31'd0, o_rdy}, 32'd1);
        beat({48'd0, 16'd7}, 4'b1111, 1'b1);
        collect("rst2", 24'd7, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
